wave_sequencer: RTL and testbench
=================================

Name: wave_sequencer

Overview:
Sequencer for the dual-table waveform memory (sine and triangle tables, selected by channel). It paces table reads with a programmable divider and steps the address through 0..N-1 with wrap. It latches the channel and divider only at period boundaries and presents each sample on a valid/ready output toward the downstream DAC/serializer.

Parameters:
N, 16, table depth in samples; requires N <= 2**logsize.
size, 12, sample width in bits.
logsize, 4, memory address width.
DIVW, 16, width of the divider input.

Ports:
clk  input  1  system clock; everything is on the rising edge.
rst  input  1  asynchronous, active-low reset.
enable  input  1  run request; level-sensitive.
channel_sel  input  1  1 = sine table, 0 = triangle table; latched at start and at wrap only.
div  input  DIVW  idle cycles before each read, minus one; latched at start and at wrap only.
mem_read  output  1  one-cycle read strobe to the memory.
mem_channel  output  1  latched channel; stable whenever mem_read = 1.
mem_address  output  logsize  current table index.
mem_sample  input  size  memory data, valid the cycle after mem_read.
out_sample  output  size  registered sample.
out_valid  output  1  out_sample is valid; held until accepted.
out_ready  input  1  downstream accepts when out_valid & out_ready.
period_start  output  1  one-cycle pulse with the out_valid cycle that carries address 0.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: when rst = 0, asynchronously force state=IDLE, cnt=0, addr=0, ch_l=0, div_l=0, out_sample=0. All outputs 0.
- Memory contract: synchronous read, 1-cycle latency. mem_read and mem_address in cycle k give mem_sample valid in cycle k+1.
- FSM states: IDLE, WAIT, READ, CAPT, OUT.
- IDLE:
  - addr=0.
  - If enable=1: latch ch_l<=channel_sel, div_l<=div, cnt<=div; go to WAIT.
- WAIT:
  - If enable=0: go to IDLE; addr<=0.
  - Else if cnt=0: go to READ.
  - Else: cnt<=cnt-1.
  - WAIT lasts div_l+1 cycles.
- READ: mem_read=1 for exactly this cycle, mem_address=addr, mem_channel=ch_l; go to CAPT.
- CAPT: out_sample<=mem_sample; go to OUT.
- OUT:
  - out_valid=1. period_start=1 iff addr=0 (asserted on the first out_valid cycle only).
  - out_sample is held stable while out_valid=1.
  - On out_ready=1 (transfer):
    - If addr=N-1: addr<=0, ch_l<=channel_sel, div_l<=div, cnt<=div.
    - Else: addr<=addr+1, cnt<=div_l.
    - Go to WAIT.
  - If out_ready=0: hold; no timeout and no sample drop (backpressure stalls the sequence).
  - Ignore enable in OUT, READ and CAPT; a started read always completes its handshake.
- Throughput: with out_ready held high, consecutive mem_read strobes are div_l+4 cycles apart.
- Wrap: the address sequence is 0,1,...,N-1,0. There is no gap beyond the normal interval.
- Mid-period changes: channel_sel and div take effect only from the read of address 0 after a wrap, or on restart from IDLE.
- div=0: WAIT lasts 1 cycle, giving a minimum period of 4 cycles.
- mem_channel drives ch_l continuously. mem_address drives addr continuously. mem_read is 0 outside READ.
- Reset mid-operation: immediate return to the reset state, including deasserting out_valid; no pending transfer survives.

Test Plan:
- Reset/idle: hold rst=0, then release with enable=0 for 10 cycles -> every output stays 0 and busy=0.
- Basic timing: N=16, div=2, out_ready=1, channel_sel=1, enable rises at cycle 0.
  - -> First mem_read at cycle 4 with address 0 and mem_channel=1; out_valid at cycle 6 with period_start=1.
  - -> Strobes every 6 cycles; address goes 0..15 then 0; period_start pulses once per 16 samples.
- Backpressure: hold out_ready=0 for 20 cycles during OUT -> out_valid and out_sample stay constant, no mem_read occurs; the address advances only after out_ready=1.
- Boundary latch: change channel_sel 1->0 and div 2->0 while at address 5.
  - -> Addresses 6..15 still read with mem_channel=1 and a 6-cycle spacing.
  - -> From address 0 onward: mem_channel=0 and a 4-cycle spacing.
- Stop/restart:
  - Drop enable during WAIT at address 9 -> IDLE next cycle, addr=0.
  - Drop enable during OUT -> the transfer completes, then IDLE.
  - Re-enable -> the sequence restarts at address 0.
- Async reset: assert rst=0 mid-READ, between clock edges -> mem_read and out_valid go to 0 immediately; after release the block is in IDLE with address 0.

Source files
------------

// File: rtl/wave_sequencer.sv
// -----------------------------------------------------------------------------
// wave_sequencer
//   Paces reads of the dual-table waveform memory (sine / triangle) and hands
//   each sample downstream over a valid/ready port. The read address steps
//   0..N-1 and wraps. Channel and divider are sampled on start from IDLE and
//   at the wrap back to address 0, so a period is never mixed.
//
//   Per sample: WAIT (div_l+1 cycles) -> READ (strobe) -> CAPT (memory data
//   lands) -> OUT (hold until accepted). With out_ready high, strobes are
//   div_l+4 cycles apart.
//
// Parameters
//   N        table depth in samples (must not exceed 2**logsize)
//   size     sample width
//   logsize  memory address width
//   DIVW     divider width
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   enable        level-sensitive run request
//   channel_sel   1 = sine, 0 = triangle
//   div           idle cycles before each read, minus one
//   mem_read      one-cycle read strobe
//   mem_channel   latched channel toward the memory
//   mem_address   current table index
//   mem_sample    memory data, valid the cycle after mem_read
//   out_sample    registered sample, held while out_valid
//   out_valid     sample available downstream
//   out_ready     downstream accept
//   period_start  one-cycle pulse on the first out_valid cycle of address 0
//   busy          high in every state except IDLE
// -----------------------------------------------------------------------------
module wave_sequencer #(
  parameter int N       = 16,
  parameter int size    = 12,
  parameter int logsize = 4,
  parameter int DIVW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               channel_sel,
  input  logic [DIVW-1:0]    div,
  output logic               mem_read,
  output logic               mem_channel,
  output logic [logsize-1:0] mem_address,
  input  logic [size-1:0]    mem_sample,
  output logic [size-1:0]    out_sample,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               period_start,
  output logic               busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] READ = 3'd2;
  localparam logic [2:0] CAPT = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  localparam logic [logsize-1:0] LAST_ADDR = logsize'(N - 1);

  logic [2:0]         state;
  logic [DIVW-1:0]    cnt;
  logic [DIVW-1:0]    div_l;
  logic [logsize-1:0] addr;
  logic               ch_l;
  // Marks the first OUT cycle so period_start stays a single-cycle pulse
  // even when backpressure stretches OUT.
  logic               first_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div_l      <= '0;
      addr       <= '0;
      ch_l       <= 1'b0;
      out_sample <= '0;
      first_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          addr <= '0;
          if (enable) begin
            ch_l  <= channel_sel;
            div_l <= div;
            cnt   <= div;
            state <= WAIT;
          end
        end

        // Only state where enable is honoured; READ/CAPT/OUT always finish
        // their handshake first.
        WAIT: begin
          if (!enable) begin
            addr  <= '0;
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= READ;
          end else begin
            cnt <= cnt - DIVW'(1);
          end
        end

        READ: state <= CAPT;

        CAPT: begin
          out_sample <= mem_sample;
          first_q    <= 1'b1;
          state      <= OUT;
        end

        OUT: begin
          first_q <= 1'b0;
          if (out_ready) begin
            if (addr == LAST_ADDR) begin
              // Period boundary: pick up new channel/divider for address 0.
              addr  <= '0;
              ch_l  <= channel_sel;
              div_l <= div;
              cnt   <= div;
            end else begin
              addr <= addr + logsize'(1);
              cnt  <= div_l;
            end
            state <= WAIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly, so an asynchronous reset
  // drops mem_read/out_valid without waiting for a clock.
  assign mem_read     = (state == READ);
  assign out_valid    = (state == OUT);
  assign busy         = (state != IDLE);
  assign period_start = out_valid && first_q && (addr == '0);
  assign mem_channel  = ch_l;
  assign mem_address  = addr;

endmodule

// File: tb/tb_wave_sequencer.sv
module tb_wave_sequencer;
  localparam int N = 16, SIZE = 12, LOGSIZE = 4, DIVW = 16;

  logic               clk = 1'b0, rst = 1'b0, enable = 1'b0, channel_sel = 1'b0, out_ready = 1'b0;
  logic [DIVW-1:0]    div = '0;
  logic               mem_read, mem_channel, out_valid, period_start, busy;
  logic [LOGSIZE-1:0] mem_address;
  logic [SIZE-1:0]    mem_sample = '0, out_sample;

  always #5 clk = ~clk;

  wave_sequencer #(.N(N), .size(SIZE), .logsize(LOGSIZE), .DIVW(DIVW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .channel_sel(channel_sel), .div(div),
    .mem_read(mem_read), .mem_channel(mem_channel), .mem_address(mem_address),
    .mem_sample(mem_sample), .out_sample(out_sample), .out_valid(out_valid),
    .out_ready(out_ready), .period_start(period_start), .busy(busy)
  );

  // Table contents: distinct values per channel and address.
  function automatic logic [SIZE-1:0] rom(input logic ch, input logic [LOGSIZE-1:0] a);
    return ch ? SIZE'(12'h800 + 37 * int'(a)) : SIZE'(12'h0A0 + 11 * int'(a));
  endfunction

  // Synchronous-read memory, one cycle latency.
  always @(posedge clk) if (mem_read) mem_sample <= rom(mem_channel, mem_address);

  int n_assert = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [SIZE-1:0] smp; logic ps;} exp_t;
  typedef struct {int cyc; int addr; logic ch;} rd_t;
  exp_t sb[$];
  rd_t  rlog[$];
  int   ovlog[$];
  int   pslog[$];
  logic ov_q = 1'b0;

  // Scoreboard: expectation pushed on each read strobe, compared on every
  // out_valid cycle (covers hold stability), popped on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      ov_q <= 1'b0;
    end else begin
      if (mem_read) begin
        sb.push_back('{rom(mem_channel, mem_address), mem_address == '0});
        rlog.push_back('{cyc, int'(mem_address), mem_channel});
      end
      if (out_valid) begin
        if (sb.size() == 0) check("sb_empty_on_valid", 1, 0);
        else begin
          check("out_sample", out_sample, sb[0].smp);
          check("period_start", period_start, (!ov_q) ? sb[0].ps : 1'b0);
          if (out_ready) void'(sb.pop_front());
        end
        if (!ov_q) ovlog.push_back(cyc);
      end
      if (period_start) pslog.push_back(cyc);
      ov_q <= out_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_reads(input int k, input string name);
    int b = 0;
    while (rlog.size() < k && b < 2000) begin tick(1); b++; end
    check(name, rlog.size() >= k, 1);
  endtask

  int t0 = 0;
  task automatic start_run(input logic ch, input logic [DIVW-1:0] d);
    int b = 0;
    enable = 1'b0; out_ready = 1'b1;
    while (busy && b < 200) begin tick(1); b++; end
    check("idle_before_run", busy, 0);
    rlog.delete(); ovlog.delete(); pslog.delete();
    channel_sel = ch; div = d; enable = 1'b1; t0 = cyc;
  endtask

  typedef struct {logic ch; logic [DIVW-1:0] d; int first_rd; int first_ov; int gap;} vec_t;
  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, a, nr;
    vecs[0] = '{1'b1, 16'd2, 4, 6, 6};
    vecs[1] = '{1'b0, 16'd0, 2, 4, 4};
    vecs[2] = '{1'b1, 16'd5, 7, 9, 9};
    vecs[3] = '{1'b0, 16'd1, 3, 5, 5};

    // Reset and idle
    tick(3);
    check("reset_outs", {mem_read, mem_channel, mem_address, out_sample, out_valid, period_start, busy}, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle_outs", {mem_read, mem_channel, mem_address, out_sample, out_valid, period_start, busy}, 0);
    end

    // Table-driven timing runs across a wrap
    for (int v = 0; v < 4; v++) begin
      start_run(vecs[v].ch, vecs[v].d);
      wait_reads(17, "run_reads_timeout");
      tick(4);
      if (rlog.size() >= 17 && ovlog.size() >= 1) begin
        check("first_read_cycle", rlog[0].cyc - t0, vecs[v].first_rd);
        check("first_valid_cycle", ovlog[0] - t0, vecs[v].first_ov);
        for (int i = 0; i < 17; i++) begin
          check("read_addr", rlog[i].addr, i % N);
          check("read_channel", rlog[i].ch, vecs[v].ch);
          if (i > 0) check("read_gap", rlog[i].cyc - rlog[i-1].cyc, vecs[v].gap);
        end
        check("period_pulses", pslog.size(), 2);
        if (pslog.size() > 0) check("ps_with_first_valid", pslog[0], ovlog[0]);
      end
    end

    // Backpressure: 20 stalled cycles in OUT
    start_run(1'b1, 16'd2);
    wait_reads(3, "bp_reads_timeout");
    out_ready = 1'b0;
    b = 0;
    while (!out_valid && b < 50) begin tick(1); b++; end
    check("bp_reach_out", out_valid, 1);
    a = int'(mem_address); nr = rlog.size();
    tick(20);
    check("bp_no_read", rlog.size(), nr);
    check("bp_valid_held", out_valid, 1);
    check("bp_addr_held", mem_address, a);
    out_ready = 1'b1;
    tick(1);
    check("bp_addr_adv", mem_address, a + 1);
    check("bp_valid_drop", out_valid, 0);

    // Boundary latch: new channel/div only after the wrap
    start_run(1'b1, 16'd2);
    wait_reads(6, "latch_reads_timeout");
    channel_sel = 1'b0; div = 16'd0;
    wait_reads(19, "latch_reads2_timeout");
    if (rlog.size() >= 19)
      for (int i = 6; i < 19; i++) begin
        check("latch_addr", rlog[i].addr, i % N);
        check("latch_channel", rlog[i].ch, i < 16);
        check("latch_gap", rlog[i].cyc - rlog[i-1].cyc, (i < 16) ? 6 : 4);
      end

    // Stop in WAIT at address 9
    start_run(1'b1, 16'd2);
    b = 0;
    while (mem_address != 4'd9 && b < 200) begin tick(1); b++; end
    check("stop_reach_addr9", mem_address, 9);
    enable = 1'b0;
    tick(1);
    check("stop_wait_idle", busy, 0);
    check("stop_wait_addr", mem_address, 0);
    check("stop_no_read9", rlog.size(), 9);

    // Stop in OUT: transfer completes, then IDLE
    rlog.delete();
    enable = 1'b1;
    b = 0;
    while (!out_valid && b < 50) begin tick(1); b++; end
    check("stop_reach_out", out_valid, 1);
    enable = 1'b0;
    tick(1);
    check("stop_out_busy", busy, 1);
    check("stop_out_addr", mem_address, 1);
    tick(1);
    check("stop_out_idle", busy, 0);
    check("stop_out_addr0", mem_address, 0);

    // Restart from address 0
    rlog.delete();
    enable = 1'b1;
    wait_reads(1, "restart_timeout");
    if (rlog.size() >= 1) check("restart_addr", rlog[0].addr, 0);

    // Asynchronous reset in the middle of READ
    wait_reads(3, "ares_reads_timeout");
    b = 0;
    while (!mem_read && b < 50) begin tick(1); b++; end
    check("ares_reach_read", mem_read, 1);
    #2 rst = 1'b0;
    #1;
    check("ares_read_low", mem_read, 0);
    check("ares_valid_low", out_valid, 0);
    check("ares_busy_low", busy, 0);
    enable = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    check("ares_idle", busy, 0);
    check("ares_addr", mem_address, 0);
    check("ares_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
